// File: rtl/alarm_controller.sv
// alarm_controller
// ----------------
// Decides when the alarm fires and sequences ring / snooze / dismiss.
// The block sits between the alarm-setting counters, the time-of-day
// counters, and the display/sounder logic.
//
// Ports:
//   clk          in   system clock
//   clear        in   synchronous active-high reset
//   sec_tick     in   one-cycle pulse per second
//   enable       in   alarm on/off switch (level)
//   dismiss      in   one-cycle pulse, stop the alarm
//   snooze       in   one-cycle pulse, snooze request
//   cur_hour     in   current hour   (0..23)
//   cur_min      in   current minute (0..59)
//   alarm_hour   in   alarm hour   (0..23 or UNSET)
//   alarm_min    in   alarm minute (0..59 or UNSET)
//   state        out  DISARMED=0, ARMED=1, RINGING=2, SNOOZING=3
//   ringing      out  high while in RINGING
//   buzzer       out  beep pattern, toggles once per second while ringing
//   alarm_event  out  one-cycle pulse on every entry to RINGING
//   snooze_count out  snoozes used in the current alarm event
module alarm_controller #(
    parameter logic [6:0] UNSET        = 7'h7F,
    parameter int         SNOOZE_MIN   = 5,
    parameter int         MAX_SNOOZE   = 3,
    parameter int         RING_TIMEOUT = 60
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       sec_tick,
    input  logic       enable,
    input  logic       dismiss,
    input  logic       snooze,
    input  logic [6:0] cur_hour,
    input  logic [6:0] cur_min,
    input  logic [6:0] alarm_hour,
    input  logic [6:0] alarm_min,
    output logic [1:0] state,
    output logic       ringing,
    output logic       buzzer,
    output logic       alarm_event,
    output logic [1:0] snooze_count
);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZING = 2'd3
    } state_t;

    localparam logic [11:0] SNOOZE_LOAD  = 12'(SNOOZE_MIN * 60);
    localparam logic [6:0]  RING_LIMIT   = 7'(RING_TIMEOUT);
    localparam logic [1:0]  SNOOZE_LIMIT = 2'(MAX_SNOOZE);

    state_t      state_q, state_d;
    logic [1:0]  snooze_cnt_q, snooze_cnt_d;
    logic [11:0] snooze_tmr_q, snooze_tmr_d;
    logic [6:0]  ring_cnt_q, ring_cnt_d;
    logic        buzzer_q, buzzer_d;
    logic        event_q, event_d;
    logic        match_prev_q;

    logic        alarm_set_s;
    logic        match_now_s;
    logic        trigger_s;

    assign alarm_set_s = (alarm_hour != UNSET) && (alarm_min != UNSET);
    assign match_now_s = alarm_set_s && (cur_hour == alarm_hour) && (cur_min == alarm_min);
    // Rising edge of the match: only the first cycle of the matching minute fires.
    assign trigger_s   = match_now_s && !match_prev_q;

    // Next-state and next-output computation.
    always_comb begin
        state_d      = state_q;
        snooze_cnt_d = snooze_cnt_q;
        snooze_tmr_d = snooze_tmr_q;
        ring_cnt_d   = ring_cnt_q;
        buzzer_d     = buzzer_q;
        event_d      = 1'b0;

        if (!enable || !alarm_set_s) begin
            state_d      = DISARMED;
            snooze_cnt_d = 2'd0;
            snooze_tmr_d = 12'd0;
            ring_cnt_d   = 7'd0;
            buzzer_d     = 1'b0;
        end else begin
            case (state_q)
                DISARMED: begin
                    state_d = ARMED;
                end
                ARMED: begin
                    // A dismiss pulse outranks a trigger arriving on the same edge.
                    if (trigger_s && !dismiss) begin
                        state_d    = RINGING;
                        event_d    = 1'b1;
                        ring_cnt_d = 7'd0;
                        buzzer_d   = 1'b1;
                    end else begin
                        state_d = ARMED;
                    end
                end
                RINGING: begin
                    // Snooze with the allowance exhausted behaves as dismiss.
                    if (dismiss || (snooze && (snooze_cnt_q == SNOOZE_LIMIT))) begin
                        state_d      = ARMED;
                        snooze_cnt_d = 2'd0;
                        buzzer_d     = 1'b0;
                    end else if (snooze) begin
                        state_d      = SNOOZING;
                        snooze_cnt_d = snooze_cnt_q + 2'd1;
                        snooze_tmr_d = SNOOZE_LOAD;
                        buzzer_d     = 1'b0;
                    end else if (sec_tick) begin
                        ring_cnt_d = ring_cnt_q + 7'd1;
                        if ((ring_cnt_q + 7'd1) == RING_LIMIT) begin
                            state_d      = ARMED;
                            snooze_cnt_d = 2'd0;
                            buzzer_d     = 1'b0;
                        end else begin
                            buzzer_d = !buzzer_q;
                        end
                    end else begin
                        state_d = RINGING;
                    end
                end
                SNOOZING: begin
                    if (dismiss) begin
                        state_d      = ARMED;
                        snooze_cnt_d = 2'd0;
                    end else if (sec_tick) begin
                        snooze_tmr_d = snooze_tmr_q - 12'd1;
                        if (snooze_tmr_q == 12'd1) begin
                            state_d    = RINGING;
                            event_d    = 1'b1;
                            ring_cnt_d = 7'd0;
                            buzzer_d   = 1'b1;
                        end else begin
                            state_d = SNOOZING;
                        end
                    end else begin
                        state_d = SNOOZING;
                    end
                end
                default: begin
                    state_d      = DISARMED;
                    snooze_cnt_d = 2'd0;
                    buzzer_d     = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= DISARMED;
            snooze_cnt_q <= 2'd0;
            snooze_tmr_q <= 12'd0;
            ring_cnt_q   <= 7'd0;
            buzzer_q     <= 1'b0;
            event_q      <= 1'b0;
            match_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            snooze_cnt_q <= snooze_cnt_d;
            snooze_tmr_q <= snooze_tmr_d;
            ring_cnt_q   <= ring_cnt_d;
            buzzer_q     <= buzzer_d;
            event_q      <= event_d;
            match_prev_q <= match_now_s;
        end
    end

    assign state        = state_q;
    assign ringing      = (state_q == RINGING);
    assign buzzer       = buzzer_q;
    assign alarm_event  = event_q;
    assign snooze_count = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard testbench for alarm_controller: directed scenarios followed by
// randomized traffic, checked against a behavioural reference model.
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       sec_tick = 1'b0;
    logic       enable = 1'b0;
    logic       dismiss = 1'b0;
    logic       snooze = 1'b0;
    logic [6:0] cur_hour = 7'd0;
    logic [6:0] cur_min = 7'd0;
    logic [6:0] alarm_hour = 7'h7F;
    logic [6:0] alarm_min = 7'h7F;
    logic [1:0] state;
    logic       ringing;
    logic       buzzer;
    logic       alarm_event;
    logic [1:0] snooze_count;

    always #5 clk = ~clk;

    alarm_controller dut (
        .clk         (clk),
        .clear       (clear),
        .sec_tick    (sec_tick),
        .enable      (enable),
        .dismiss     (dismiss),
        .snooze      (snooze),
        .cur_hour    (cur_hour),
        .cur_min     (cur_min),
        .alarm_hour  (alarm_hour),
        .alarm_min   (alarm_min),
        .state       (state),
        .ringing     (ringing),
        .buzzer      (buzzer),
        .alarm_event (alarm_event),
        .snooze_count(snooze_count)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       rg;
        logic       bz;
        logic       ev;
        logic [1:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: state as an int, snooze as "seconds left",
    // ringing as "seconds rung so far"; the buzzer is high on even seconds.
    int m_state = 0;
    int m_cnt   = 0;
    int m_left  = 0;
    int m_secs  = 0;
    bit m_prev  = 1'b0;
    bit m_event = 1'b0;

    function automatic void ring_start();
        m_state = 2;
        m_secs  = 0;
        m_event = 1'b1;
    endfunction

    function automatic void model_step();
        bit is_set;
        bit match;
        bit trig;
        is_set  = (alarm_hour != 7'h7F) && (alarm_min != 7'h7F);
        match   = is_set && (cur_hour == alarm_hour) && (cur_min == alarm_min);
        trig    = match && !m_prev;
        m_event = 1'b0;
        if (clear) begin
            m_state = 0; m_cnt = 0; m_left = 0; m_secs = 0; m_prev = 1'b0;
        end else begin
            if (!enable || !is_set) begin
                m_state = 0; m_cnt = 0;
            end else if (m_state == 0) begin
                m_state = 1;
            end else if (m_state == 1) begin
                if (trig && !dismiss) ring_start();
            end else if (m_state == 2) begin
                if (dismiss || (snooze && m_cnt == 3)) begin
                    m_state = 1; m_cnt = 0;
                end else if (snooze) begin
                    m_state = 3; m_cnt = m_cnt + 1; m_left = 5 * 60;
                end else if (sec_tick) begin
                    m_secs = m_secs + 1;
                    if (m_secs == 60) begin
                        m_state = 1; m_cnt = 0;
                    end
                end
            end else begin
                if (dismiss) begin
                    m_state = 1; m_cnt = 0;
                end else if (sec_tick) begin
                    m_left = m_left - 1;
                    if (m_left == 0) ring_start();
                end
            end
            m_prev = match;
        end
    endfunction

    // One clock of stimulus: model the coming edge, queue its expected outputs.
    task automatic step(input bit tick = 1'b0, input bit dsm = 1'b0, input bit snz = 1'b0);
        exp_t e;
        sec_tick = tick;
        dismiss  = dsm;
        snooze   = snz;
        model_step();
        e.st = 2'(m_state);
        e.rg = (m_state == 2);
        e.bz = (m_state == 2) && (m_secs % 2 == 0);
        e.ev = m_event;
        e.sc = 2'(m_cnt);
        exp_q.push_back(e);
        @(negedge clk);
        sec_tick = 1'b0;
        dismiss  = 1'b0;
        snooze   = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents one set of outputs after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state",        int'(state),        int'(e.st));
                check("ringing",      int'(ringing),      int'(e.rg));
                check("buzzer",       int'(buzzer),       int'(e.bz));
                check("alarm_event",  int'(alarm_event),  int'(e.ev));
                check("snooze_count", int'(snooze_count), int'(e.sc));
            end
        end
    end

    initial begin
        @(negedge clk);
        // Reset.
        clear = 1'b1; step(); clear = 1'b0;

        // Fire at 07:30, then hold the minute without a second event.
        alarm_hour = 7'd7; alarm_min = 7'd30; cur_hour = 7'd7; cur_min = 7'd29;
        enable = 1'b1;
        repeat (3) step();
        cur_min = 7'd30; step();
        repeat (100) step();

        // Timeout after 60 ticks.
        repeat (62) step(1'b1);

        // Snooze three times, then a fourth snooze acts as dismiss.
        cur_min = 7'd31; step();
        cur_min = 7'd30; step();
        repeat (3) begin
            step(1'b0, 1'b0, 1'b1);
            repeat (300) step(1'b1);
            step();
        end
        step(1'b0, 1'b0, 1'b1);
        step();

        // Unset alarm keeps DISARMED; disabling mid-ring disarms.
        alarm_min = 7'h7F; repeat (3) step();
        cur_min = 7'd29; alarm_min = 7'd30; repeat (2) step();
        cur_min = 7'd30; step();
        step(1'b1);
        enable = 1'b0; step();

        // Arm inside a matching minute, then next-day repeat fires.
        alarm_hour = 7'd6; alarm_min = 7'd0; cur_hour = 7'd6; cur_min = 7'd0;
        step();
        enable = 1'b1; repeat (100) step(1'($urandom_range(0, 1)));
        cur_hour = 7'd5; cur_min = 7'd59; step();
        cur_hour = 7'd6; cur_min = 7'd0; step();

        // dismiss + snooze together: dismiss wins.
        step(1'b1, 1'b1, 1'b1);
        step();

        // Clear while snoozing.
        cur_hour = 7'd5; cur_min = 7'd59; step();
        cur_hour = 7'd6; cur_min = 7'd0; step();
        step(1'b0, 1'b0, 1'b1);
        repeat (5) step(1'b1);
        clear = 1'b1; step(); clear = 1'b0;
        step();

        // Randomized traffic around a couple of alarm times.
        for (int i = 0; i < 4000; i++) begin
            bit dsm;
            bit snz;
            if ($urandom_range(0, 15) == 0) begin
                cur_hour = 7'($urandom_range(6, 7));
                cur_min  = ($urandom_range(0, 1) == 0) ? 7'd29 : 7'd30;
            end
            if ($urandom_range(0, 199) == 0) alarm_min = 7'h7F;
            else if ($urandom_range(0, 99) == 0) alarm_min = 7'd30;
            if ($urandom_range(0, 299) == 0) alarm_hour = 7'($urandom_range(6, 7));
            enable = ($urandom_range(0, 99) != 0);
            clear  = ($urandom_range(0, 499) == 0);
            dsm = 1'b0;
            snz = 1'b0;
            if (m_state >= 2) begin
                dsm = ($urandom_range(0, 59) == 0);
                snz = ($urandom_range(0, 29) == 0);
            end
            step(1'($urandom_range(0, 1)), dsm, snz);
            clear = 1'b0;
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
